register_serial_reader: RTL and testbench
=========================================

// Module: register_serial_reader
// PURPOSE
//   Read-side counterpart to the 32-bit D-flip-flop register: on request it captures the
//   register's parallel Q word and streams it out one bit per accepted beat.
//   Uses a valid/ready handshake and reports busy/done status.
//   Sits between register storage and any serial consumer (debug port, bus bridge, checker).
// PARAMETERS
//   WIDTH      32  word width captured from the register; must be >= 2
//   MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//   clk         in   1      system clock; all state changes on the rising edge
//   rst_n       in   1      synchronous, active-low reset, sampled on rising clk
//   rd_req      in   1      request a read; sampled only in IDLE
//   rd_data     in   WIDTH  parallel register contents (register Q bus)
//   rd_ack      out  1      one-cycle pulse: rd_data was captured
//   sout        out  1      current serial bit
//   sout_valid  out  1      sout holds a valid bit
//   sout_ready  in   1      consumer accepts sout this cycle
//   busy        out  1      a transaction is in progress (SHIFT or DONE)
//   done        out  1      one-cycle pulse after the last bit is accepted
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state=IDLE; shift reg=0; count=0.
//     All outputs are 0 after that edge. This applies at any point, including mid-transfer.
//     The aborted word is discarded, and done is not pulsed.
//   State register is a 2-bit FSM: IDLE, SHIFT, DONE.
//   IDLE: busy=0, sout_valid=0, sout=0.
//     If rd_req=1 at an edge, then on that edge: shreg<=rd_data, count<=WIDTH, state<=SHIFT.
//     In the following cycle rd_ack=1 for exactly one cycle.
//   SHIFT: busy=1, sout_valid=1.
//     sout = shreg[WIDTH-1] if MSB_FIRST, otherwise shreg[0].
//     A beat transfers at an edge where sout_valid & sout_ready.
//       On that edge the shreg shifts toward the output end, zero-filled, and count decrements.
//     If sout_ready=0, sout and shreg hold stable; there is no timeout.
//     When the beat with count==1 transfers: state<=DONE.
//   DONE: busy=1, sout_valid=0, done=1 for one cycle, then unconditionally IDLE.
//   rd_req while busy (SHIFT/DONE): ignored, no rd_ack, no effect on the stream.
//     It must be held or reasserted in IDLE to start a new read.
//   Back-to-back reads: rd_req held high starts the next read on the first IDLE edge.
//     Minimum period is WIDTH+2 cycles per word.
//   Latency: request edge k gives rd_ack=1 and the first sout_valid=1 in cycle k+1.
//     With sout_ready tied high, the last bit is in cycle k+WIDTH and done in cycle k+WIDTH+1.
//   rd_data is sampled only on the capture edge; later changes do not affect the stream.
//   count width is clog2(WIDTH+1) and never wraps below 0 (SHIFT exits at 1).
//   Simultaneous rst_n=0 and rd_req=1: reset wins, no capture.
// TESTING
//   1. rst_n=0 for 2 edges with rd_req=1 -> rd_ack, sout_valid, busy, done, sout all 0.
//   2. MSB_FIRST=1, rd_data=32'hA5A5_0F0F, sout_ready=1:
//      -> bits 1,0,1,0,0,1,0,1,... captured in cycles k+1..k+32, and done=1 in cycle k+33.
//   3. Backpressure: same word, sout_ready toggles 1,0,0,1,...
//      -> sout is stable while ready=0, the 32 accepted bits equal A5A50F0F, and done appears once.
//   4. rd_req pulsed in cycle k+5 of a transfer, and rd_data changed mid-stream:
//      -> no second rd_ack, and the stream is unchanged.
//   5. rst_n=0 in cycle k+10 of a transfer -> IDLE next edge, done never asserted.
//      A new rd_req then streams the new word from bit 0 of the count.
//   6. MSB_FIRST=0, rd_data=32'h0000_0001 -> first sout=1, then 31 zeros.
//      rd_req held high gives a second rd_ack exactly 34 cycles after the first.

Source files
------------

// File: rtl/register_serial_reader_if.sv
// ============================================================================
//  Module   : register_serial_reader_if
//  Purpose  : Request, capture and serial-stream signals that connect a
//             register serial reader to its requester and serial consumer.
//  Signals  : rd_req      requester -> reader  start a read (sampled in IDLE)
//             rd_data     requester -> reader  parallel register Q word
//             rd_ack      reader -> requester  one-cycle capture pulse
//             sout        reader -> consumer   current serial bit
//             sout_valid  reader -> consumer   sout holds a valid bit
//             sout_ready  consumer -> reader   consumer accepts sout
//             busy        reader -> all        transaction in progress
//             done        reader -> all        one-cycle end-of-word pulse
//  Modports : slave  - the reader itself
//             master - the requester/consumer side driving the reader
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface register_serial_reader_if #(
  parameter int WIDTH = 32
);
  logic             rd_req;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ack;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             busy;
  logic             done;

  modport slave (
    input  rd_req, rd_data, sout_ready,
    output rd_ack, sout, sout_valid, busy, done
  );

  modport master (
    output rd_req, rd_data, sout_ready,
    input  rd_ack, sout, sout_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/register_serial_reader.sv
// ============================================================================
//  Module   : register_serial_reader
//  Purpose  : Captures a register's parallel Q word on request and streams it
//             out one bit per accepted valid/ready beat, with busy/done status.
//  Ports    : clk    in   system clock, rising-edge active
//             rst_n  in   synchronous active-low reset
//             bus    slave modport of register_serial_reader_if
//                    (rd_req/rd_data in, rd_ack out, sout/sout_valid out,
//                     sout_ready in, busy/done out)
//  Params   : WIDTH      captured word width (>= 2)
//             MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_serial_reader #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  register_serial_reader_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_ack;
  logic             w_ack_nxt;

  logic             w_out_bit;
  logic [WIDTH-1:0] w_shifted;
  logic             w_sout;
  logic             w_sout_valid;
  logic             w_busy;
  logic             w_done;

  // The output end of the shift register depends on bit order; the register
  // always shifts toward that end with zero fill.
  if (MSB_FIRST) begin : g_msb_first
    assign w_out_bit = r_shreg[WIDTH-1];
    assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
  end else begin : g_lsb_first
    assign w_out_bit = r_shreg[0];
    assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_count <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_count <= w_count_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_count_nxt  = r_count;
    w_ack_nxt    = 1'b0;
    w_sout       = 1'b0;
    w_sout_valid = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.rd_req) begin
          w_shreg_nxt = bus.rd_data;
          w_count_nxt = c_CNT_FULL;
          w_state_nxt = S_SHIFT;
          // rd_ack is a registered pulse, so it appears in the cycle after
          // the capture edge, alongside the first valid bit.
          w_ack_nxt   = 1'b1;
        end
      end

      S_SHIFT: begin
        w_busy       = 1'b1;
        w_sout_valid = 1'b1;
        w_sout       = w_out_bit;
        if (bus.sout_ready) begin
          w_shreg_nxt = w_shifted;
          w_count_nxt = r_count - c_CNT_ONE;
          // Leaving on the last beat keeps the count from ever wrapping.
          if (r_count == c_CNT_ONE) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.rd_ack     = r_ack;
  assign bus.sout       = w_sout;
  assign bus.sout_valid = w_sout_valid;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;

endmodule

`default_nettype wire

// File: tb/tb_register_serial_reader.sv
// ============================================================================
//  Module   : tb_register_serial_reader
//  Purpose  : Directed self-checking bench for register_serial_reader; one
//             MSB-first and one LSB-first instance share clock and reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_serial_reader;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  register_serial_reader_if #(.WIDTH(32)) bus_m ();
  register_serial_reader_if #(.WIDTH(32)) bus_l ();

  register_serial_reader #(.WIDTH(32), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m.slave)
  );

  register_serial_reader #(.WIDTH(32), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] word;
    int          bits;
    int          dones;
    int          acks;
    int          second;
    logic        ready;
    logic        prev_stall;
    logic        prev_sout;
    logic        seen_done;

    // ---------------- 1: reset with rd_req asserted ----------------
    rst_n = 1'b0;
    bus_m.rd_req = 1'b1; bus_m.rd_data = 32'hFFFF_FFFF; bus_m.sout_ready = 1'b1;
    bus_l.rd_req = 1'b1; bus_l.rd_data = 32'hFFFF_FFFF; bus_l.sout_ready = 1'b1;
    tick();
    tick();
    chk("rst_ack",   bus_m.rd_ack,     1'b0);
    chk("rst_valid", bus_m.sout_valid, 1'b0);
    chk("rst_busy",  bus_m.busy,       1'b0);
    chk("rst_done",  bus_m.done,       1'b0);
    chk("rst_sout",  bus_m.sout,       1'b0);
    chk("rst_l_ack", bus_l.rd_ack,     1'b0);
    chk("rst_l_busy", bus_l.busy,      1'b0);
    bus_m.rd_req = 1'b0;
    bus_l.rd_req = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_valid", bus_m.sout_valid, 1'b0);

    // ---------------- 2: MSB first, ready tied high ----------------
    bus_m.rd_data = 32'hA5A5_0F0F;
    bus_m.rd_req  = 1'b1;
    tick();
    bus_m.rd_req = 1'b0;
    chk("t2_ack", bus_m.rd_ack, 1'b1);
    word = '0;
    for (int i = 0; i < 32; i++) begin
      chk("t2_valid", bus_m.sout_valid, 1'b1);
      if (i == 1) chk("t2_ack_pulse", bus_m.rd_ack, 1'b0);
      if (i < 4)  chk("t2_first_bits", bus_m.sout, (i == 0 || i == 2) ? 1'b1 : 1'b0);
      word = {word[30:0], bus_m.sout};
      tick();
    end
    chk("t2_word",      word,             32'hA5A5_0F0F);
    chk("t2_done",      bus_m.done,       1'b1);
    chk("t2_done_busy", bus_m.busy,       1'b1);
    chk("t2_done_vld",  bus_m.sout_valid, 1'b0);
    tick();
    chk("t2_idle_done", bus_m.done, 1'b0);
    chk("t2_idle_busy", bus_m.busy, 1'b0);

    // ---------------- 3: backpressure ----------------
    bus_m.rd_req = 1'b1;
    tick();
    bus_m.rd_req = 1'b0;
    word = '0; bits = 0; dones = 0; prev_stall = 1'b0; prev_sout = 1'b0;
    for (int c = 0; c < 110; c++) begin
      if (bus_m.done) dones++;
      if (prev_stall) chk("t3_hold", bus_m.sout, prev_sout);
      ready = (c % 3 == 0);
      bus_m.sout_ready = ready;
      if (bus_m.sout_valid && ready) begin
        word = {word[30:0], bus_m.sout};
        bits++;
      end
      prev_stall = bus_m.sout_valid && !ready;
      prev_sout  = bus_m.sout;
      tick();
    end
    bus_m.sout_ready = 1'b1;
    chk("t3_bits",  bits,  32);
    chk("t3_word",  word,  32'hA5A5_0F0F);
    chk("t3_dones", dones, 1);

    // ---------------- 4: rd_req while busy, rd_data changes ----------------
    bus_m.rd_data = 32'h1234_5678;
    bus_m.rd_req  = 1'b1;
    tick();
    bus_m.rd_req = 1'b0;
    chk("t4_ack", bus_m.rd_ack, 1'b1);
    acks = 1; word = '0;
    for (int c = 0; c < 34; c++) begin
      if (c > 0 && bus_m.rd_ack) acks++;
      if (c == 3) bus_m.rd_data = 32'hFFFF_FFFF;
      bus_m.rd_req = (c == 5);
      if (bus_m.sout_valid) word = {word[30:0], bus_m.sout};
      tick();
    end
    bus_m.rd_req = 1'b0;
    chk("t4_acks", acks, 1);
    chk("t4_word", word, 32'h1234_5678);

    // ---------------- 5: reset mid-transfer ----------------
    bus_m.rd_data = 32'hDEAD_BEEF;
    bus_m.rd_req  = 1'b1;
    tick();
    bus_m.rd_req = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus_m.done) seen_done = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("t5_busy",  bus_m.busy,       1'b0);
    chk("t5_valid", bus_m.sout_valid, 1'b0);
    chk("t5_sout",  bus_m.sout,       1'b0);
    chk("t5_ack",   bus_m.rd_ack,     1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (bus_m.done) seen_done = 1'b1;
      tick();
    end
    chk("t5_no_done", seen_done, 1'b0);
    bus_m.rd_data = 32'h0F0F_F0F0;
    bus_m.rd_req  = 1'b1;
    tick();
    bus_m.rd_req = 1'b0;
    word = '0;
    for (int i = 0; i < 32; i++) begin
      word = {word[30:0], bus_m.sout};
      tick();
    end
    chk("t5_word", word,       32'h0F0F_F0F0);
    chk("t5_done", bus_m.done, 1'b1);

    // ---------------- 6: LSB first, back-to-back reads ----------------
    bus_l.rd_data = 32'h0000_0001;
    bus_l.rd_req  = 1'b1;
    tick();
    chk("t6_ack", bus_l.rd_ack, 1'b1);
    word = '0; second = -1;
    for (int t = 0; t < 60; t++) begin
      if (t == 0) chk("t6_first", bus_l.sout, 1'b1);
      if (t < 32) word = {bus_l.sout, word[31:1]};
      if (t > 0 && bus_l.rd_ack && second < 0) second = t;
      tick();
    end
    bus_l.rd_req = 1'b0;
    chk("t6_word",   word,   32'h0000_0001);
    chk("t6_period", second, 34);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
